// File: rtl/divider_8by4_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arith_pkg
// Description : Shared arithmetic datapath definitions. Holds the operand
//               widths, the sequential divider state encoding and the
//               divide-by-zero quotient code.
//               Contents:
//                 DW, VW         dividend/quotient and divisor/remainder widths
//                 state_e        2-bit divider control state {IDLE, RUN, DONE}
//                 DBZ_QUOTIENT   quotient reported for a zero divisor (all ones)
// Revision    : 1.0 - initial release
// ============================================================================
package arith_pkg;

  localparam int DW = 8;
  localparam int VW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [DW-1:0] DBZ_QUOTIENT = '1;

endpackage
`default_nettype wire

// File: rtl/divider_8by4_seq_div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring-division iteration, purely combinational.
//               Compares the shifted partial remainder against the divisor
//               and subtracts when it fits.
// Ports       : p_shift_i  [VW:0]   partial remainder after the left shift
//               divisor_i  [VW-1:0] divisor
//               p_next_o   [VW:0]   restored partial remainder
//               qbit_o              quotient bit produced by this iteration
// Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
  parameter int VW = 4
) (
  input  logic [VW:0]   p_shift_i,
  input  logic [VW-1:0] divisor_i,
  output logic [VW:0]   p_next_o,
  output logic          qbit_o
);

  logic [VW:0] w_dvs_ext;
  logic [VW:0] w_diff;

  assign w_dvs_ext = {1'b0, divisor_i};
  assign w_diff    = p_shift_i - w_dvs_ext;

  always_comb begin
    qbit_o   = (p_shift_i >= w_dvs_ext);
    p_next_o = qbit_o ? w_diff : p_shift_i;
  end

endmodule
`default_nettype wire

// File: rtl/divider_8by4_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_8by4_seq
// Description : Sequential restoring divider, DW-bit dividend by VW-bit
//               divisor, one quotient bit per clock. Results appear 8 clocks
//               after the accepting edge and are held until the next
//               completion.
// Ports       : clk        rising-edge clock
//               rst        synchronous active-high reset
//               start      request, sampled only while ready=1
//               dividend   [DW-1:0] numerator, sampled on the accepting edge
//               divisor    [VW-1:0] denominator, sampled on the accepting edge
//               ready      a new start will be accepted (IDLE or DONE)
//               busy       iterations in progress
//               done       one-cycle completion pulse
//               dbz        latest result was a divide by zero
//               quotient   [DW-1:0] registered quotient
//               remainder  [VW-1:0] registered remainder
// Revision    : 1.0 - initial release
// ============================================================================
module divider_8by4_seq #(
  parameter int DW = arith_pkg::DW,
  parameter int VW = arith_pkg::VW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          dbz,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(DW - 1);

  arith_pkg::state_e state_q, state_d;

  logic [CW-1:0] count_q;
  logic [DW-1:0] dvd_q;     // dividend shift register, MSB feeds P
  logic [VW-1:0] dvs_q;
  logic [VW:0]   p_q;       // partial remainder, extra bit for the compare
  logic [DW-1:0] quo_q;     // quotient bits accumulate from the LSB
  logic          zero_q;    // divisor was zero at accept

  logic          w_accept;
  logic [VW:0]   w_p_shift;
  logic [VW:0]   w_p_next;
  logic          w_qbit;
  logic [DW-1:0] w_quo_next;

  assign w_accept   = start & ready;
  assign w_p_shift  = {p_q[VW-1:0], dvd_q[DW-1]};
  assign w_quo_next = {quo_q[DW-2:0], w_qbit};

  div_step #(.VW(VW)) u_step (
    .p_shift_i (w_p_shift),
    .divisor_i (dvs_q),
    .p_next_o  (w_p_next),
    .qbit_o    (w_qbit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= arith_pkg::IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      arith_pkg::IDLE: if (start) state_d = arith_pkg::RUN;
      arith_pkg::RUN:  if (count_q == C_LAST) state_d = arith_pkg::DONE;
      arith_pkg::DONE: state_d = start ? arith_pkg::RUN : arith_pkg::IDLE;
      default:         state_d = arith_pkg::IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    ready = (state_q == arith_pkg::IDLE) || (state_q == arith_pkg::DONE);
    busy  = (state_q == arith_pkg::RUN);
    done  = (state_q == arith_pkg::DONE);
  end

  // Datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      p_q       <= '0;
      quo_q     <= '0;
      zero_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else if (w_accept) begin
      dvd_q   <= dividend;
      dvs_q   <= divisor;
      p_q     <= '0;
      quo_q   <= '0;
      count_q <= '0;
      zero_q  <= (divisor == '0);
    end else if (state_q == arith_pkg::RUN) begin
      dvd_q   <= {dvd_q[DW-2:0], 1'b0};
      p_q     <= w_p_next;
      quo_q   <= w_quo_next;
      count_q <= count_q + 1'b1;
      if (count_q == C_LAST) begin
        // Restoration keeps P below the divisor, so its top bit is zero here.
        quotient  <= zero_q ? '1 : w_quo_next;
        remainder <= zero_q ? '0 : w_p_next[VW-1:0];
        dbz       <= zero_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_divider_8by4_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_8by4_seq
// Description : Scoreboard testbench for divider_8by4_seq. Directed vectors
//               push hand-computed results; a monitor pops and compares on
//               every done pulse and checks that results hold in between.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divider_8by4_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       ready, busy, done, dbz;
  logic [7:0] quotient;
  logic [3:0] remainder;

  divider_8by4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .dbz       (dbz),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         acc;
  } exp_t;

  exp_t sb[$];
  exp_t hold;
  int   tests = 0;
  int   errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;
  bit   mon_en = 0;
  bit   prev_done = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (busy) busy_cnt++;
        if (done) begin
          chk("done_single_pulse", int'(prev_done), 0);
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", quotient, e.q);
            chk("remainder", remainder, e.r);
            chk("dbz", dbz, e.z);
            chk("latency", cyc - e.acc, 8);
            chk("busy_cycles", busy_cnt, 8);
            hold = e;
          end
          busy_cnt = 0;
        end else begin
          chk("held_result", {quotient, remainder, dbz}, {hold.q, hold.r, hold.z});
        end
        prev_done = done;
      end
    end
  end

  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] q, input logic [3:0] r, input logic z);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
    start = 1'b1; dividend = a; divisor = b;
    e.q = q; e.r = r; e.z = z; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; dividend = 8'h5A; divisor = 4'h3;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(sb.size() == 0 && ready) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk("completion_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    sb.delete();
    hold.q = '0; hold.r = '0; hold.z = 1'b0;
    busy_cnt = 0;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
  endtask

  initial begin
    exp_t e;
    int n;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    hold.q = '0; hold.r = '0; hold.z = 1'b0; hold.acc = 0;
    @(negedge clk);
    do_reset(2);
    chk_reset_state();
    mon_en = 1;

    // Basic vectors
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    wait_idle();
    issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    wait_idle();
    issue(8'd143, 4'd11, 8'd13, 4'd0, 1'b0);
    wait_idle();
    issue(8'd0, 4'd9, 8'd0, 4'd0, 1'b0);
    wait_idle();
    issue(8'd15, 4'd15, 8'd1, 4'd0, 1'b0);
    wait_idle();

    // Divide by zero, then a normal division clears the flag
    issue(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1);
    wait_idle();
    issue(8'd100, 4'd3, 8'd33, 4'd1, 1'b0);
    wait_idle();

    // Start held through DONE: second operation accepted on the DONE edge
    @(negedge clk);
    start = 1'b1; dividend = 8'd255; divisor = 4'd1;
    e.q = 8'd255; e.r = 4'd0; e.z = 1'b0; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    dividend = 8'd60; divisor = 4'd7;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("held_start_timeout", 0, 1);
    e.q = 8'd8; e.r = 4'd4; e.z = 1'b0; e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Start pulsed mid-run is ignored
    issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 4'd3;
    chk("busy_when_ignored", busy, 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (12) @(negedge clk);

    // Reset during iteration 4 aborts the operation
    issue(8'd77, 4'd5, 8'd15, 4'd2, 1'b0);
    repeat (4) @(negedge clk);
    do_reset(1);
    chk_reset_state();
    repeat (10) @(negedge clk);
    chk("no_done_after_abort", sb.size(), 0);
    issue(8'd50, 4'd6, 8'd8, 4'd2, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
